// File: rtl/prog_sequencer_if.sv
// Bus between the program sequencer and its surroundings (decoder, ALU
// flags, data memory, instruction ROM).
//   master modport : drives the decoded instruction / memory status inputs
//                    and observes the sequencer outputs
//   slave modport  : the sequencer itself
// Signals:
//   Start, BranchEn, Jump, Taken, Ack, MemAccess, MemReady : control inputs
//   Target[PC_W]     : absolute branch target
//   ProgCtr[PC_W]    : instruction ROM address
//   InstrValid, Stall, Done : state flags
//   CycleCnt[16]     : executed-cycle count
interface prog_sequencer_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic            BranchEn;
  logic            Jump;
  logic            Taken;
  logic            Ack;
  logic            MemAccess;
  logic            MemReady;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] ProgCtr;
  logic            InstrValid;
  logic            Stall;
  logic            Done;
  logic [15:0]     CycleCnt;

  modport master (
    output Start, BranchEn, Jump, Taken, Ack, MemAccess, MemReady, Target,
    input  ProgCtr, InstrValid, Stall, Done, CycleCnt
  );

  modport slave (
    input  Start, BranchEn, Jump, Taken, Ack, MemAccess, MemReady, Target,
    output ProgCtr, InstrValid, Stall, Done, CycleCnt
  );
endinterface

// File: rtl/prog_sequencer.sv
// Program counter sequencer with IDLE / RUN / STALL / DONE control.
// Ports:
//   Clk   : single clock, all state changes on its rising edge
//   Reset : synchronous active-high reset, overrides everything
//   bus   : prog_sequencer_if.slave (control inputs, ProgCtr and flags)
// Parameters:
//   PC_W       : program counter width
//   START_ADDR : PC value loaded on reset and on an accepted Start
// Optional feature:
//   PROG_SEQUENCER_CYCLE_COUNT_EN : when defined, CycleCnt counts cycles spent
//   in RUN or STALL (cleared on Start, saturating). When undefined CycleCnt
//   is tied to zero and no counter register exists.
module prog_sequencer #(
  parameter int          PC_W       = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic           Clk,
  input  logic           Reset,
  prog_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] ONE      = PC_W'(1);
  localparam logic [PC_W-1:0] TWO      = PC_W'(2);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      pc_reg    <= START_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Next-state / next-PC. PC additions wrap naturally at PC_W bits.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_next = RUN;
          pc_next    = START_PC;
        end
      end
      RUN: begin
        // Priority: halt, memory wait, branch, skip, sequential.
        if (bus.Ack) begin
          state_next = DONE;
        end else if (bus.MemAccess && !bus.MemReady) begin
          state_next = STALL;
        end else if (bus.BranchEn) begin
          pc_next = bus.Taken ? bus.Target : pc_reg + ONE;
        end else if (bus.Jump) begin
          pc_next = bus.Taken ? pc_reg + TWO : pc_reg + ONE;
        end else begin
          pc_next = pc_reg + ONE;
        end
      end
      STALL: begin
        // The stalled instruction completes once memory is ready.
        if (bus.MemReady) begin
          state_next = RUN;
          pc_next    = pc_reg + ONE;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = START_PC;
      end
    endcase
  end

  assign bus.ProgCtr    = pc_reg;
  assign bus.InstrValid = (state_reg == RUN);
  assign bus.Stall      = (state_reg == STALL);
  assign bus.Done       = (state_reg == DONE);

`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
  logic [15:0] cnt_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_reg <= 16'd0;
    end else if ((state_reg == IDLE || state_reg == DONE) && bus.Start) begin
      cnt_reg <= 16'd0;
    end else if ((state_reg == RUN || state_reg == STALL) && cnt_reg != 16'hFFFF) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign bus.CycleCnt = cnt_reg;
`else
  assign bus.CycleCnt = 16'd0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: reset, sequential fetch, branch, skip
// with wrap, memory stall, halt/restart and reset during a stall.
module tb_prog_sequencer;
  localparam int PC_W = 10;
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  prog_sequencer_if #(.PC_W(PC_W)) bus ();

  prog_sequencer #(.PC_W(PC_W), .START_ADDR(0)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit st, input bit br, input bit jp, input bit tk,
                       input bit ak, input bit ma, input bit mr,
                       input int tgt);
    bus.Start     = st;
    bus.BranchEn  = br;
    bus.Jump      = jp;
    bus.Taken     = tk;
    bus.Ack       = ak;
    bus.MemAccess = ma;
    bus.MemReady  = mr;
    bus.Target    = PC_W'(tgt);
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs against hand-computed values; cnt is the count the
  // counter would hold when the feature is built in.
  task automatic expect_out(input string tag, input int pc, input bit iv,
                            input bit st, input bit dn, input int cnt);
    check({tag, ".pc"},    int'(bus.ProgCtr), pc);
    check({tag, ".valid"}, int'(bus.InstrValid), int'(iv));
    check({tag, ".stall"}, int'(bus.Stall), int'(st));
    check({tag, ".done"},  int'(bus.Done), int'(dn));
    check({tag, ".cnt"},   int'(bus.CycleCnt), CNT_EN ? cnt : 0);
    $display("%0t %s pc=%0h valid=%0b stall=%0b done=%0b cnt=%0d",
             $time, tag, bus.ProgCtr, bus.InstrValid, bus.Stall, bus.Done,
             bus.CycleCnt);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    expect_out("reset", 0, 0, 0, 0, 0);

    // Inputs other than Start are ignored in IDLE.
    rst = 1'b0;
    drive(0, 1, 0, 1, 0, 0, 0, 'h55);
    step();
    expect_out("idle_ignore", 0, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    expect_out("start", 0, 1, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); expect_out("seq1", 1, 1, 0, 0, 1);
    step(); expect_out("seq2", 2, 1, 0, 0, 2);
    step(); expect_out("seq3", 3, 1, 0, 0, 3);

    // Start has no effect while running.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step(); expect_out("start_in_run", 4, 1, 0, 0, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); expect_out("seq5", 5, 1, 0, 0, 5);

    drive(0, 1, 0, 1, 0, 0, 0, 'h3A);
    step(); expect_out("br_taken", 'h3A, 1, 0, 0, 6);
    drive(0, 1, 0, 1, 0, 0, 0, 5);
    step(); expect_out("br_back5", 5, 1, 0, 0, 7);
    drive(0, 1, 0, 0, 0, 0, 0, 'h3A);
    step(); expect_out("br_not_taken", 6, 1, 0, 0, 8);

    // Skip from the top of the address space wraps to 1.
    drive(0, 1, 0, 1, 0, 0, 0, 'h3FF);
    step(); expect_out("br_top", 'h3FF, 1, 0, 0, 9);
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    step(); expect_out("jmp_wrap", 1, 1, 0, 0, 10);
    drive(0, 1, 0, 1, 0, 0, 0, 'h3FF);
    step(); expect_out("br_top2", 'h3FF, 1, 0, 0, 11);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); expect_out("inc_wrap", 0, 1, 0, 0, 12);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    step(); expect_out("jmp_not_taken", 1, 1, 0, 0, 13);
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    step(); expect_out("jmp_taken", 3, 1, 0, 0, 14);

    // Memory stall at PC 7 for three cycles; branch inputs ignored in STALL.
    drive(0, 1, 0, 1, 0, 0, 0, 7);
    step(); expect_out("br_to7", 7, 1, 0, 0, 15);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    step(); expect_out("stall1", 7, 0, 1, 0, 16);
    drive(0, 1, 0, 1, 0, 1, 0, 'h100);
    step(); expect_out("stall2", 7, 0, 1, 0, 17);
    step(); expect_out("stall3", 7, 0, 1, 0, 18);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    step(); expect_out("stall_exit", 8, 1, 0, 0, 19);
    // Access completing immediately does not stall.
    step(); expect_out("mem_ready_run", 9, 1, 0, 0, 20);

    // Halt at PC 9 (Ack wins over a pending stall), then restart.
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    step(); expect_out("halt", 9, 0, 0, 1, 21);
    drive(0, 1, 0, 1, 0, 0, 0, 'h20);
    step(); expect_out("done_hold", 9, 0, 0, 1, 21);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step(); expect_out("restart", 0, 1, 0, 0, 0);

    // Reset in the middle of a stall; Start ignored in STALL.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); expect_out("seq_r1", 1, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    step(); expect_out("stall_r", 1, 0, 1, 0, 2);
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    step(); expect_out("start_in_stall", 1, 0, 1, 0, 3);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    step(); expect_out("reset_in_stall", 0, 0, 0, 0, 0);

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); expect_out("post_reset_idle", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
